// File: rtl/ref_line_feeder_if.sv
// Bundles the row-memory read port, the line-register write port and the
// pass control signals of the reference line feeder.
//
// Handshake: line_write_en is the feeder's valid. A line transfers on a
// rising clk edge where line_write_en && line_ready. While line_write_en is
// high, line_out stays stable until that transfer. line_ready has no effect
// while line_write_en is low. rd_data is sampled by the feeder exactly one
// cycle after it raises rd_en.
interface ref_line_feeder_if #(
    parameter int ADDR_W = 3
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [63:0]       rd_data;
    logic              line_write_en;
    logic signed [71:0] line_out;
    logic              line_ready;

    // Feeder side.
    modport master (
        input  start, rd_data, line_ready,
        output busy, done, rd_en, rd_addr, line_write_en, line_out
    );

    // Memory / line-register / controller side.
    modport slave (
        output start, rd_data, line_ready,
        input  busy, done, rd_en, rd_addr, line_write_en, line_out
    );
endinterface

// File: rtl/ref_line_feeder.sv
// Reads reference-block rows and emits padded 9-sample lines
// ({s0, s0..s7}) for the interpolation line registers, replicating the first
// and last rows for top/bottom padding.
module ref_line_feeder #(
    parameter int NUM_ROWS = 8,
    parameter int ADDR_W   = 3,
    parameter int PAD_TOP  = 1,
    parameter int PAD_BOT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    ref_line_feeder_if.master bus,
    output logic [2:0]        dbg_state
);
    localparam int LINES = PAD_TOP + NUM_ROWS + PAD_BOT;
    localparam int CNT_W = $clog2(LINES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        EMIT   = 3'd3,
        DONEST = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_line;
    logic             handshake;

    // Source row for line idx: pad lines clamp onto the edge rows and are
    // re-read from memory rather than cached.
    function automatic logic [ADDR_W-1:0] row_of(input int idx);
        int r;
        r = idx - PAD_TOP;
        if (r < 0) begin
            r = 0;
        end else if (r > NUM_ROWS - 1) begin
            r = NUM_ROWS - 1;
        end
        return ADDR_W'(r);
    endfunction

    assign last_line = (int'(cnt) == LINES - 1);
    assign handshake = (state == EMIT) && bus.line_ready;

    // State register; reset aborts any pass in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one fetch, one wait for memory, then hold the line until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = EMIT;
            EMIT: begin
                if (handshake) begin
                    state_nxt = last_line ? DONEST : FETCH;
                end
            end
            DONEST:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line counter, read address and captured line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            bus.rd_addr  <= '0;
            bus.line_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt         <= '0;
                        bus.rd_addr <= row_of(0);
                    end
                end
                WAIT: begin
                    // Pad sample replicates s0 bit-exactly; no arithmetic.
                    bus.line_out <= {bus.rd_data[63:56], bus.rd_data};
                end
                EMIT: begin
                    if (handshake && !last_line) begin
                        cnt         <= cnt + CNT_W'(1);
                        bus.rd_addr <= row_of(int'(cnt) + 1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.rd_en         = (state == FETCH);
    assign bus.line_write_en = (state == EMIT);
    assign bus.done          = (state == DONEST);
    assign dbg_state         = state;
endmodule

// File: tb/tb_ref_line_feeder.sv
// Randomized self-checking bench for ref_line_feeder: two instances (default
// geometry, and a one-row block with two top pads), row memories modelled in
// the bench, expected lines derived from the padding/clamping rules.
module tb_ref_line_feeder;
    localparam int L1 = 1 + 8 + 1;
    localparam int L2 = 2 + 1 + 0;

    logic clk;
    logic rst;
    logic [2:0] dbg1;
    logic [2:0] dbg2;

    logic [63:0] mem1 [8];
    logic [63:0] mem2;

    int checks;
    int failures;

    ref_line_feeder_if #(.ADDR_W(3)) bus1 ();
    ref_line_feeder_if #(.ADDR_W(3)) bus2 ();

    ref_line_feeder #(.NUM_ROWS(8), .ADDR_W(3), .PAD_TOP(1), .PAD_BOT(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .dbg_state (dbg1)
    );

    ref_line_feeder #(.NUM_ROWS(1), .ADDR_W(3), .PAD_TOP(2), .PAD_BOT(0)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .dbg_state (dbg2)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row memories: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus1.rd_en) bus1.rd_data <= mem1[bus1.rd_addr];
        if (bus2.rd_en) bus2.rd_data <= mem2;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic int row_for(input int i, input int pad_top, input int num_rows);
        int r;
        r = i - pad_top;
        if (r < 0) r = 0;
        if (r > num_rows - 1) r = num_rows - 1;
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 72'(bus1.busy), 72'(0));
        check_eq({tag, "_done"}, 72'(bus1.done), 72'(0));
        check_eq({tag, "_rd_en"}, 72'(bus1.rd_en), 72'(0));
        check_eq({tag, "_lwe"}, 72'(bus1.line_write_en), 72'(0));
        check_eq({tag, "_rd_addr"}, 72'(bus1.rd_addr), 72'(0));
        check_eq({tag, "_line_out"}, bus1.line_out, 72'(0));
    endtask

    // One pass on instance 1. stall_line/stall_len: hold ready low on that
    // line; pulse_a/pulse_b: cycles with START high during the pass;
    // abort_line: assert reset while that line is offered; rand_ready:
    // random ready everywhere.
    task automatic run_pass(input int stall_line, input int stall_len, input int pulse_a,
                            input int pulse_b, input int abort_line, input bit rand_ready);
        logic [71:0] exp_q[$];
        logic [71:0] last_line;
        int lines, stalls, stall_cnt, done_cyc, done_cnt, first_lwe;
        bit ready;
        for (int i = 0; i < L1; i++) begin
            int r;
            logic [63:0] row;
            r = row_for(i, 1, 8);
            row = mem1[r];
            exp_q.push_back({row[63:56], row});
        end
        last_line = exp_q[L1-1];
        lines = 0; stalls = 0; stall_cnt = 0; done_cyc = -1; done_cnt = 0; first_lwe = -1;
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.line_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            bus1.start = (cyc == pulse_a) || (cyc == pulse_b);
            if (bus1.rd_en) begin
                check_eq("rd_addr", 72'(bus1.rd_addr), 72'(row_for(lines, 1, 8)));
            end
            if (bus1.line_write_en) begin
                if (first_lwe < 0) first_lwe = cyc;
                if (exp_q.size() == 0) check_eq("extra_line", 72'(1), 72'(0));
                else check_eq("line_data", bus1.line_out, exp_q[0]);
                check_eq("rd_en_in_emit", 72'(bus1.rd_en), 72'(0));
                if (lines == abort_line) begin
                    rst = 1'b1;
                    #1;
                    check_idle_outputs("abort");
                    @(negedge clk);
                    rst = 1'b0;
                    bus1.start = 1'b0;
                    bus1.line_ready = 1'b1;
                    for (int k = 0; k < 6; k++) begin
                        @(negedge clk);
                        check_eq("post_abort_quiet",
                                 72'({bus1.busy, bus1.rd_en, bus1.line_write_en, bus1.done}), 72'(0));
                    end
                    return;
                end
                if (lines == stall_line && stall_cnt < stall_len) begin
                    ready = 1'b0;
                    stall_cnt++;
                end else if (rand_ready) begin
                    ready = 1'($urandom_range(0, 1));
                end else begin
                    ready = 1'b1;
                end
                bus1.line_ready = ready;
                if (!ready) stalls++;
                else begin
                    void'(exp_q.pop_front());
                    lines++;
                end
            end else begin
                bus1.line_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (bus1.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc < 0 || cyc == done_cyc) check_eq("busy_high", 72'(bus1.busy), 72'(1));
            else check_eq("busy_low", 72'(bus1.busy), 72'(0));
            if (done_cyc >= 0 && cyc >= done_cyc + 8) break;
            @(negedge clk);
        end
        bus1.start = 1'b0;
        check_eq("done_seen", 72'(done_cyc >= 0), 72'(1));
        check_eq("done_count", 72'(done_cnt), 72'(1));
        check_eq("line_count", 72'(lines), 72'(L1));
        check_eq("first_lwe_cycle", 72'(first_lwe), 72'(3));
        check_eq("done_cycle", 72'(done_cyc), 72'(3 * L1 + 1 + stalls));
        check_eq("line_out_hold", bus1.line_out, last_line);
    endtask

    task automatic fill_counting();
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
                mem1[r][63-8*k -: 8] = 8'(16 * r + k);
            end
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++) mem1[r] = {$urandom(), $urandom()};
    endtask

    // Corner geometry: one row, two top pads, no bottom pad.
    task automatic run_corner();
        logic [71:0] exp_line;
        int lines, done_cyc;
        exp_line = {mem2[63:56], mem2};
        lines = 0; done_cyc = -1;
        @(negedge clk);
        bus2.start = 1'b1;
        bus2.line_ready = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (bus2.rd_en) check_eq("c_rd_addr", 72'(bus2.rd_addr), 72'(0));
            if (bus2.line_write_en) begin
                check_eq("c_line_data", bus2.line_out, exp_line);
                lines++;
            end
            if (bus2.done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        check_eq("c_line_count", 72'(lines), 72'(L2));
        check_eq("c_done_cycle", 72'(done_cyc), 72'(3 * L2 + 1));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus1.start = 1'b0;
        bus1.line_ready = 1'b0;
        bus1.rd_data = '0;
        bus2.start = 1'b0;
        bus2.line_ready = 1'b0;
        bus2.rd_data = '0;
        mem2 = 64'h0001020304050607;
        fill_counting();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset2_busy", 72'({bus2.busy, bus2.line_write_en, bus2.line_out}), 72'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic pass, ready tied high.
        run_pass(-1, 0, -1, -1, -1, 1'b0);
        // Backpressure: five stalled cycles on line 4.
        run_pass(4, 5, -1, -1, -1, 1'b0);
        // START while busy, including in the DONE cycle.
        run_pass(-1, 0, 5, 31, -1, 1'b0);
        // Random data, random ready.
        for (int p = 0; p < 3; p++) begin
            fill_random();
            run_pass(-1, 0, $urandom_range(2, 20), -1, -1, 1'b1);
        end
        // Reset while line 6 is offered, then a full replay.
        fill_counting();
        run_pass(-1, 0, -1, -1, 6, 1'b0);
        run_pass(-1, 0, -1, -1, -1, 1'b0);
        // Negative samples: pad replicates the raw top byte.
        mem1[0] = 64'h80FF7F0001020304;
        run_pass(-1, 0, -1, -1, -1, 1'b0);
        // One-row block with two top pads.
        run_corner();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
